framebuffer_avn_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter in front of the SRAM frame-buffer controller's framebuffer_avn slave port.
- Master 0 is the video daisy-chain pixel writer and is write-only. Master 1 is a host/debug port that can read and write, for frame-buffer clear, readback and test patterns.
- Uses round-robin with a burst limit, so the streaming writer cannot starve the host and the host cannot stall the pixel pipeline indefinitely.
- Tracks outstanding reads in an ID FIFO and routes readdata back to the master that issued the read.

---
 rtl/fb_arb_pkg.sv | 18 +
 rtl/fb_arb_id_fifo.sv | 53 +++++
 rtl/framebuffer_avn_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_framebuffer_avn_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer Avalon-MM two-master arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0_ID = 1'b0;
    localparam master_id_t M1_ID = 1'b1;

    // Wide enough for MAX_BURST up to 255.
    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fb_arb_id_fifo.sv
// Read-ID FIFO: remembers which master issued each outstanding read so the
// response can be routed back in order. DEPTH must be a power of 2, >= 2.
module fb_arb_id_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  master_id_t wdata,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output master_id_t rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    master_id_t  mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= M0_ID;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/framebuffer_avn_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with burst limit and in-order read
// routing. Define FB_ARB_PERF_CNT_EN to add accept/stall performance counters.
module framebuffer_avn_arbiter
    import fb_arb_pkg::*;
#(
    parameter int AVN_AW         = 18,
    parameter int AVN_DW         = 16,
    parameter int MAX_BURST      = 16,
    parameter int RD_OUTSTANDING = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [AVN_AW-1:0]   m0_avn_address,
    input  logic                m0_avn_write,
    input  logic [AVN_DW-1:0]   m0_avn_writedata,
    input  logic [AVN_DW/8-1:0] m0_avn_byteenable,
    output logic                m0_avn_waitrequest,
    input  logic [AVN_AW-1:0]   m1_avn_address,
    input  logic                m1_avn_read,
    input  logic                m1_avn_write,
    input  logic [AVN_DW-1:0]   m1_avn_writedata,
    input  logic [AVN_DW/8-1:0] m1_avn_byteenable,
    output logic                m1_avn_waitrequest,
    output logic [AVN_DW-1:0]   m1_avn_readdata,
    output logic                m1_avn_readdatavalid,
    output logic [AVN_AW-1:0]   framebuffer_avn_address,
    output logic                framebuffer_avn_read,
    output logic                framebuffer_avn_write,
    output logic [AVN_DW-1:0]   framebuffer_avn_writedata,
    output logic [AVN_DW/8-1:0] framebuffer_avn_byteenable,
    input  logic                framebuffer_avn_waitrequest,
    input  logic [AVN_DW-1:0]   framebuffer_avn_readdata,
    input  logic                framebuffer_avn_readdatavalid,
`ifdef FB_ARB_PERF_CNT_EN
    output logic [31:0]         perf_m0_cnt,
    output logic [31:0]         perf_m1_cnt,
    output logic [31:0]         perf_stall_cnt,
`endif
    output logic                rsp_err
);

    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);
    localparam logic [BURST_CNT_W-1:0] BURST_ONE  = {{(BURST_CNT_W-1){1'b0}}, 1'b1};

    arb_state_t             state_r;
    arb_state_t             state_s;
    logic [BURST_CNT_W-1:0] burst_cnt_r;
    logic [BURST_CNT_W-1:0] burst_cnt_s;
    master_id_t             last_winner_r;
    master_id_t             last_winner_s;
    logic                   rsp_err_r;

    logic       req0_s;
    logic       req1_s;
    logic       rd_block_s;
    logic       accept_s;
    logic       burst_done_s;
    logic       fifo_push_s;
    logic       fifo_pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    master_id_t fifo_rdata_s;

    assign req0_s       = m0_avn_write;
    assign req1_s       = m1_avn_read | m1_avn_write;
    // A full ID FIFO blocks host reads even when a response pops this cycle.
    assign rd_block_s   = (state_r == GNT1) & m1_avn_read & fifo_full_s;
    assign accept_s     = (framebuffer_avn_read | framebuffer_avn_write) & ~framebuffer_avn_waitrequest;
    assign burst_done_s = accept_s & (burst_cnt_r == BURST_LAST);

    // Slave-side command mux and master waitrequests.
    always_comb begin
        framebuffer_avn_address    = '0;
        framebuffer_avn_read       = 1'b0;
        framebuffer_avn_write      = 1'b0;
        framebuffer_avn_writedata  = '0;
        framebuffer_avn_byteenable = '0;
        m0_avn_waitrequest         = 1'b1;
        m1_avn_waitrequest         = 1'b1;
        case (state_r)
            GNT0: begin
                framebuffer_avn_address    = m0_avn_address;
                framebuffer_avn_write      = m0_avn_write;
                framebuffer_avn_writedata  = m0_avn_writedata;
                framebuffer_avn_byteenable = m0_avn_byteenable;
                m0_avn_waitrequest         = framebuffer_avn_waitrequest;
            end
            GNT1: begin
                framebuffer_avn_address    = m1_avn_address;
                framebuffer_avn_read       = m1_avn_read & ~rd_block_s;
                framebuffer_avn_write      = m1_avn_write;
                framebuffer_avn_writedata  = m1_avn_writedata;
                framebuffer_avn_byteenable = m1_avn_byteenable;
                m1_avn_waitrequest         = framebuffer_avn_waitrequest | rd_block_s;
            end
            default: begin
                framebuffer_avn_address = '0;
            end
        endcase
    end

    // Grant FSM next state, burst count and round-robin pointer.
    always_comb begin
        state_s       = state_r;
        burst_cnt_s   = burst_cnt_r;
        last_winner_s = last_winner_r;
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    state_s = (last_winner_r == M0_ID) ? GNT1 : GNT0;
                end else if (req0_s) begin
                    state_s = GNT0;
                end else if (req1_s) begin
                    state_s = GNT1;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT0: begin
                if (!req0_s || burst_done_s) begin
                    last_winner_s = M0_ID;
                    burst_cnt_s   = '0;
                    // An exhausted burst with nobody waiting is simply re-granted.
                    if (req1_s) begin
                        state_s = GNT1;
                    end else if (req0_s) begin
                        state_s = GNT0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (accept_s) begin
                    burst_cnt_s = burst_cnt_r + BURST_ONE;
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
            end
            GNT1: begin
                if (!req1_s || burst_done_s) begin
                    last_winner_s = M1_ID;
                    burst_cnt_s   = '0;
                    if (req0_s) begin
                        state_s = GNT0;
                    end else if (req1_s) begin
                        state_s = GNT1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (accept_s) begin
                    burst_cnt_s = burst_cnt_r + BURST_ONE;
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
            end
            default: begin
                state_s     = IDLE;
                burst_cnt_s = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r       <= IDLE;
            burst_cnt_r   <= '0;
            last_winner_r <= M1_ID;
        end else begin
            state_r       <= state_s;
            burst_cnt_r   <= burst_cnt_s;
            last_winner_r <= last_winner_s;
        end
    end

    assign fifo_push_s = framebuffer_avn_read & ~framebuffer_avn_waitrequest;
    assign fifo_pop_s  = framebuffer_avn_readdatavalid & ~fifo_empty_s;

    fb_arb_id_fifo #(
        .DEPTH (RD_OUTSTANDING)
    ) u_id_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (fifo_push_s),
        .wdata (M1_ID),
        .pop   (fifo_pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .rdata (fifo_rdata_s)
    );

    assign m1_avn_readdatavalid = fifo_pop_s & (fifo_rdata_s == M1_ID);
    assign m1_avn_readdata      = m1_avn_readdatavalid ? framebuffer_avn_readdata : '0;

    // Sticky flag for a response that has no matching outstanding read.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rsp_err_r <= 1'b0;
        end else if (framebuffer_avn_readdatavalid && fifo_empty_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign rsp_err = rsp_err_r;

`ifdef FB_ARB_PERF_CNT_EN
    logic m0_acc_s;
    logic m1_acc_s;
    logic stall_s;

    assign m0_acc_s = accept_s & (state_r == GNT0);
    assign m1_acc_s = accept_s & (state_r == GNT1);
    assign stall_s  = (req0_s & m0_avn_waitrequest) | (req1_s & m1_avn_waitrequest);

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            perf_m0_cnt    <= 32'd0;
            perf_m1_cnt    <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            perf_m0_cnt    <= perf_m0_cnt + {31'd0, m0_acc_s};
            perf_m1_cnt    <= perf_m1_cnt + {31'd0, m1_acc_s};
            perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_s};
        end
    end
`endif

endmodule

// File: tb/tb_framebuffer_avn_arbiter.sv
// Directed self-checking bench for framebuffer_avn_arbiter (MAX_BURST=4,
// RD_OUTSTANDING=4) with a fixed-latency read slave model.
module tb_framebuffer_avn_arbiter;

    localparam int RD_LAT = 10;

    logic        sys_clk;
    logic        sys_rst;
    logic [17:0] m0_avn_address;
    logic        m0_avn_write;
    logic [15:0] m0_avn_writedata;
    logic [1:0]  m0_avn_byteenable;
    logic        m0_avn_waitrequest;
    logic [17:0] m1_avn_address;
    logic        m1_avn_read;
    logic        m1_avn_write;
    logic [15:0] m1_avn_writedata;
    logic [1:0]  m1_avn_byteenable;
    logic        m1_avn_waitrequest;
    logic [15:0] m1_avn_readdata;
    logic        m1_avn_readdatavalid;
    logic [17:0] framebuffer_avn_address;
    logic        framebuffer_avn_read;
    logic        framebuffer_avn_write;
    logic [15:0] framebuffer_avn_writedata;
    logic [1:0]  framebuffer_avn_byteenable;
    logic        framebuffer_avn_waitrequest;
    logic [15:0] framebuffer_avn_readdata;
    logic        framebuffer_avn_readdatavalid;
    logic        rsp_err;

    int          n_vec;
    int          n_err;
    int          cyc_n;
    int          rq_due [$];
    logic [15:0] rq_dat [$];
    logic [15:0] rx_exp [5];
    int          rx_idx;

    framebuffer_avn_arbiter #(
        .AVN_AW         (18),
        .AVN_DW         (16),
        .MAX_BURST      (4),
        .RD_OUTSTANDING (4)
    ) dut (
        .sys_clk                       (sys_clk),
        .sys_rst                       (sys_rst),
        .m0_avn_address                (m0_avn_address),
        .m0_avn_write                  (m0_avn_write),
        .m0_avn_writedata              (m0_avn_writedata),
        .m0_avn_byteenable             (m0_avn_byteenable),
        .m0_avn_waitrequest            (m0_avn_waitrequest),
        .m1_avn_address                (m1_avn_address),
        .m1_avn_read                   (m1_avn_read),
        .m1_avn_write                  (m1_avn_write),
        .m1_avn_writedata              (m1_avn_writedata),
        .m1_avn_byteenable             (m1_avn_byteenable),
        .m1_avn_waitrequest            (m1_avn_waitrequest),
        .m1_avn_readdata               (m1_avn_readdata),
        .m1_avn_readdatavalid          (m1_avn_readdatavalid),
        .framebuffer_avn_address       (framebuffer_avn_address),
        .framebuffer_avn_read          (framebuffer_avn_read),
        .framebuffer_avn_write         (framebuffer_avn_write),
        .framebuffer_avn_writedata     (framebuffer_avn_writedata),
        .framebuffer_avn_byteenable    (framebuffer_avn_byteenable),
        .framebuffer_avn_waitrequest   (framebuffer_avn_waitrequest),
        .framebuffer_avn_readdata      (framebuffer_avn_readdata),
        .framebuffer_avn_readdatavalid (framebuffer_avn_readdatavalid),
        .rsp_err                       (rsp_err)
    );

    // Free-running 10-unit clock.
    always #5 sys_clk = ~sys_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture accepted reads, advance one clock, then drive any due response.
    task automatic tick();
        if (framebuffer_avn_read && !framebuffer_avn_waitrequest) begin
            rq_due.push_back(cyc_n + RD_LAT);
            rq_dat.push_back(framebuffer_avn_address[15:0] ^ 16'hA5A5);
        end
        @(posedge sys_clk);
        #1;
        cyc_n++;
        framebuffer_avn_readdatavalid = 1'b0;
        framebuffer_avn_readdata      = 16'h0000;
        if (rq_due.size() > 0 && rq_due[0] <= cyc_n) begin
            framebuffer_avn_readdatavalid = 1'b1;
            framebuffer_avn_readdata      = rq_dat.pop_front();
            void'(rq_due.pop_front());
        end
    endtask

    task automatic do_reset();
        sys_rst      = 1'b1;
        m0_avn_write = 1'b0;
        m1_avn_read  = 1'b0;
        m1_avn_write = 1'b0;
        framebuffer_avn_waitrequest = 1'b0;
        rq_due.delete();
        rq_dat.delete();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic rx_check();
        if (m1_avn_readdatavalid) begin
            if (rx_idx < 5) begin
                check_value($sformatf("rdata%0d", rx_idx), 32'(m1_avn_readdata), 32'(rx_exp[rx_idx]));
            end
            rx_idx++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_m0_wait"}, 32'(m0_avn_waitrequest), 32'd1);
        check_value({tag, "_m1_wait"}, 32'(m1_avn_waitrequest), 32'd1);
        check_value({tag, "_fb_rd"},   32'(framebuffer_avn_read), 32'd0);
        check_value({tag, "_fb_wr"},   32'(framebuffer_avn_write), 32'd0);
        check_value({tag, "_fb_addr"}, 32'(framebuffer_avn_address), 32'd0);
        check_value({tag, "_fb_wd"},   32'(framebuffer_avn_writedata), 32'd0);
        check_value({tag, "_fb_be"},   32'(framebuffer_avn_byteenable), 32'd0);
        check_value({tag, "_m1_rdv"},  32'(m1_avn_readdatavalid), 32'd0);
        check_value({tag, "_m1_rd"},   32'(m1_avn_readdata), 32'd0);
    endtask

    initial begin
        logic [1:0]  exp_wait;
        logic [17:0] exp_addr;
        logic        w0;
        logic        w1;
        int          n0;

        n_vec = 0;
        n_err = 0;
        cyc_n = 0;
        rx_idx = 0;
        sys_clk = 1'b0;
        sys_rst = 1'b0;
        m0_avn_address = 18'd0;
        m0_avn_write = 1'b0;
        m0_avn_writedata = 16'd0;
        m0_avn_byteenable = 2'b00;
        m1_avn_address = 18'd0;
        m1_avn_read = 1'b0;
        m1_avn_write = 1'b0;
        m1_avn_writedata = 16'd0;
        m1_avn_byteenable = 2'b00;
        framebuffer_avn_waitrequest = 1'b0;
        framebuffer_avn_readdata = 16'd0;
        framebuffer_avn_readdatavalid = 1'b0;

        // Reset state.
        #1 sys_rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        check_value("rst_err", 32'(rsp_err), 32'd0);
        tick();
        sys_rst = 1'b0;

        // Pixel writer alone: three consecutive writes after a one-cycle grant delay.
        for (int c = 0; c < 5; c++) begin
            m0_avn_write      = (c < 4);
            m0_avn_address    = (c == 0) ? 18'd0 : 18'(c - 1);
            m0_avn_writedata  = 16'h1000 + 16'(c);
            m0_avn_byteenable = 2'b11;
            #1;
            if (c == 0) begin
                check_value("t1_idle_wait", 32'(m0_avn_waitrequest), 32'd1);
                check_value("t1_idle_wr", 32'(framebuffer_avn_write), 32'd0);
            end else if (c < 4) begin
                check_value($sformatf("t1_wr%0d", c), 32'(framebuffer_avn_write), 32'd1);
                check_value($sformatf("t1_addr%0d", c), 32'(framebuffer_avn_address), 32'(c - 1));
                check_value($sformatf("t1_wd%0d", c), 32'(framebuffer_avn_writedata), 32'(16'h1000 + 16'(c)));
                check_value($sformatf("t1_be%0d", c), 32'(framebuffer_avn_byteenable), 32'd3);
                check_value($sformatf("t1_m0w%0d", c), 32'(m0_avn_waitrequest), 32'd0);
                check_value($sformatf("t1_m1w%0d", c), 32'(m1_avn_waitrequest), 32'd1);
            end else begin
                check_value("t1_release_wr", 32'(framebuffer_avn_write), 32'd0);
            end
            tick();
        end

        // Both masters contend: M0 x4, M1 x4, M0 x4 with no idle gap.
        do_reset();
        m0_avn_address = 18'h00100;
        m1_avn_address = 18'h00200;
        m0_avn_write = 1'b1;
        m1_avn_write = 1'b1;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (c == 0) begin
                exp_wait = 2'b11;
                exp_addr = 18'd0;
            end else if ((((c - 1) / 4) % 2) == 0) begin
                exp_wait = 2'b01;
                exp_addr = 18'h00100;
            end else begin
                exp_wait = 2'b10;
                exp_addr = 18'h00200;
            end
            check_value($sformatf("t2_wait_c%0d", c), 32'({m0_avn_waitrequest, m1_avn_waitrequest}), 32'(exp_wait));
            check_value($sformatf("t2_addr_c%0d", c), 32'(framebuffer_avn_address), 32'(exp_addr));
            tick();
        end
        m0_avn_write = 1'b0;
        m1_avn_write = 1'b0;
        tick();

        // Writer alone past the burst limit: re-granted with no idle cycle.
        m0_avn_address = 18'h00180;
        m0_avn_write = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            check_value($sformatf("t2b_m0w_c%0d", c), 32'(m0_avn_waitrequest), (c == 0) ? 32'd1 : 32'd0);
            check_value($sformatf("t2b_m1w_c%0d", c), 32'(m1_avn_waitrequest), 32'd1);
            tick();
        end
        m0_avn_write = 1'b0;
        tick();

        // Host reads: fifth read blocked while the ID FIFO is full.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rx_exp[i] = 16'(16'h0400 + 16'(i)) ^ 16'hA5A5;
        end
        rx_idx = 0;
        n0 = 0;
        for (int c = 0; c < 32; c++) begin
            m1_avn_read    = (c < 13);
            m1_avn_address = 18'h00400 + 18'(n0);
            #1;
            rx_check();
            if (c < 13) begin
                w1 = (c == 0) || (c >= 5 && c <= 11);
                check_value($sformatf("t3_m1w_c%0d", c), 32'(m1_avn_waitrequest), 32'(w1));
                check_value($sformatf("t3_fbrd_c%0d", c), 32'(framebuffer_avn_read), 32'(!w1));
                if (!w1) begin
                    n0++;
                end
            end
            tick();
        end
        check_value("t3_rx_count", 32'(rx_idx), 32'd5);

        // Slave stall mid-burst: count frozen, command held, no early rotation.
        m0_avn_byteenable = 2'b01;
        m1_avn_address = 18'h003F0;
        n0 = 0;
        for (int c = 0; c < 11; c++) begin
            m0_avn_write = 1'b1;
            m1_avn_write = 1'b1;
            m0_avn_address = 18'h00300 + 18'(n0);
            framebuffer_avn_waitrequest = (c >= 3 && c <= 7);
            w0 = !((c >= 1 && c <= 2) || c == 8 || c == 9);
            w1 = (c != 10);
            exp_addr = (c == 0) ? 18'd0 : (c == 10) ? 18'h003F0 : 18'h00300 + 18'(n0);
            #1;
            check_value($sformatf("t4_m0w_c%0d", c), 32'(m0_avn_waitrequest), 32'(w0));
            check_value($sformatf("t4_m1w_c%0d", c), 32'(m1_avn_waitrequest), 32'(w1));
            check_value($sformatf("t4_addr_c%0d", c), 32'(framebuffer_avn_address), 32'(exp_addr));
            if (!w0) begin
                n0++;
            end
            tick();
        end
        m0_avn_write = 1'b0;
        m1_avn_write = 1'b0;
        framebuffer_avn_waitrequest = 1'b0;
        tick();

        // Response with nothing outstanding.
        check_value("t5_err_before", 32'(rsp_err), 32'd0);
        framebuffer_avn_readdatavalid = 1'b1;
        framebuffer_avn_readdata = 16'hBEEF;
        #1;
        check_value("t5_m1_rdv", 32'(m1_avn_readdatavalid), 32'd0);
        check_value("t5_m1_rd", 32'(m1_avn_readdata), 32'd0);
        tick();
        check_value("t5_err_set", 32'(rsp_err), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        check_value("t5_err_sticky", 32'(rsp_err), 32'd1);

        // Reset during GNT1 with two reads outstanding.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            m1_avn_read = 1'b1;
            m1_avn_address = 18'h00500 + ((c == 2) ? 18'd1 : 18'd0);
            #1;
            check_value($sformatf("t6_m1w_c%0d", c), 32'(m1_avn_waitrequest), (c == 0) ? 32'd1 : 32'd0);
            tick();
        end
        m1_avn_read = 1'b0;
        m1_avn_write = 1'b1;
        m1_avn_address = 18'h005AA;
        m1_avn_writedata = 16'h7777;
        m1_avn_byteenable = 2'b11;
        #1;
        check_value("t6_pre_wr", 32'(framebuffer_avn_write), 32'd1);
        check_value("t6_pre_addr", 32'(framebuffer_avn_address), 32'h005AA);
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("t6");
        check_value("t6_err_rst", 32'(rsp_err), 32'd0);
        m1_avn_write = 1'b0;
        tick();
        sys_rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (framebuffer_avn_readdatavalid) begin
                check_value($sformatf("t6_stale_rdv_c%0d", c), 32'(m1_avn_readdatavalid), 32'd0);
            end
            tick();
        end
        check_value("t6_err_late", 32'(rsp_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
